wb_regfile: RTL and testbench

- Architectural integer register file: the receiving end of the writeback port.
- Writeback drives RegWd, the destination index and the write enable into this block; decode reads two source operands from it.
- Per-register pending-write scoreboard:
  - decode marks destinations whose value arrives late (loads);
  - writeback clears the mark;
  - a combinational hazard output tells decode to stall.

---
 rtl/wb_regfile.sv | 77 +++++++
 tb/tb_wb_regfile.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: architectural register file with writeback port, two read ports
// and a per-register pending-write scoreboard that raises a decode hazard.
// Revision: 1.0
`default_nettype none

module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     rR1,
  input  logic [ADDR_W-1:0]     rR2,
  input  logic                  use1,
  input  logic                  use2,
  output logic [DATA_W-1:0]     rD1,
  output logic [DATA_W-1:0]     rD2,
  input  logic [ADDR_W-1:0]     wR,
  input  logic [DATA_W-1:0]     RegWd,
  input  logic                  RegWE,
  input  logic                  pend_set,
  input  logic [ADDR_W-1:0]     pend_rd,
  input  logic                  flush,
  output logic                  hazard,
  output logic [2**ADDR_W-1:0]  busy_vec
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic              wr_en;
  logic              hit1;
  logic              hit2;

  assign wr_en = RegWE && (wR != '0);

  // Set is applied after clear so a newer producer wins over a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wR] = 1'b0;
    if (flush) begin
      busy_d = '0;
    end else if (pend_set && (pend_rd != '0)) begin
      busy_d[pend_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (wr_en) rf_q[wR] <= RegWd;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    hit1 = (BYPASS != 0) && RegWE && (wR == rR1);
    hit2 = (BYPASS != 0) && RegWE && (wR == rR2);
    rD1  = '0;
    rD2  = '0;
    if (!rst && (rR1 != '0)) rD1 = hit1 ? RegWd : rf_q[rR1];
    if (!rst && (rR2 != '0)) rD2 = hit2 ? RegWd : rf_q[rR2];
    hazard = !rst &&
             ((use1 && (rR1 != '0) && busy_q[rR1] && !hit1) ||
              (use2 && (rR2 != '0) && busy_q[rR2] && !hit2));
  end

  assign busy_vec = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed checks of wb_regfile with and without write bypass.
`default_nettype none

module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [4:0]  rR1, rR2, wR, pend_rd;
  logic        use1, use2, RegWE, pend_set, flush;
  logic [31:0] RegWd;

  logic [31:0] rD1_b, rD2_b, rD1_n, rD2_n;
  logic        hz_b, hz_n;
  logic [31:0] bv_b, bv_n;

  int checks = 0;
  int errors = 0;

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rR1(rR1), .rR2(rR2), .use1(use1), .use2(use2),
    .rD1(rD1_b), .rD2(rD2_b), .wR(wR), .RegWd(RegWd), .RegWE(RegWE),
    .pend_set(pend_set), .pend_rd(pend_rd), .flush(flush),
    .hazard(hz_b), .busy_vec(bv_b)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .rR1(rR1), .rR2(rR2), .use1(use1), .use2(use2),
    .rD1(rD1_n), .rD2(rD2_n), .wR(wR), .RegWd(RegWd), .RegWE(RegWE),
    .pend_set(pend_set), .pend_rd(pend_rd), .flush(flush),
    .hazard(hz_n), .busy_vec(bv_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWE = 1'b0; pend_set = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rR1 = '0; rR2 = '0; wR = '0; pend_rd = '0; RegWd = '0;
    use1 = 1'b0; use2 = 1'b0; RegWE = 1'b0; pend_set = 1'b0; flush = 1'b0;
    #2;
    chk("por_rD1", rD1_b, 0);
    chk("por_busy", bv_b, 0);
    chk("por_hazard", hz_b, 0);
    @(negedge clk);
    rst = 1'b0;

    // Populate r5/r31, mark r5 pending, then reset between edges
    tick();
    RegWE = 1'b1; wR = 5'd5; RegWd = 32'h1111_1111;
    tick();
    wR = 5'd31; RegWd = 32'h2222_2222;
    tick();
    RegWE = 1'b0; pend_set = 1'b1; pend_rd = 5'd5;
    tick();
    pend_set = 1'b0; rR1 = 5'd5; rR2 = 5'd31; use1 = 1'b1;
    #1;
    chk("pre_rst_rD1", rD1_b, 32'h1111_1111);
    chk("pre_rst_rD2", rD2_b, 32'h2222_2222);
    chk("pre_rst_hazard", hz_b, 1);
    chk("pre_rst_busy", bv_b, 32'h0000_0020);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_rD1", rD1_b, 0);
    chk("rst_rD2", rD2_b, 0);
    chk("rst_rD1_nob", rD1_n, 0);
    chk("rst_busy", bv_b, 0);
    chk("rst_hazard", hz_b, 0);
    RegWE = 1'b1; wR = 5'd5; RegWd = 32'h3333_3333; pend_set = 1'b1; pend_rd = 5'd7;
    tick();
    chk("rst_hold_rD1", rD1_b, 0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("rst_drop_write", rD1_b, 0);
    chk("rst_drop_pend", bv_b, 0);

    // Write then read
    tick();
    RegWE = 1'b1; wR = 5'd7; RegWd = 32'hDEAD_BEEF; use1 = 1'b0;
    tick();
    RegWE = 1'b0; rR1 = 5'd7;
    #1;
    chk("wr_rd_byp", rD1_b, 32'hDEAD_BEEF);
    chk("wr_rd_nob", rD1_n, 32'hDEAD_BEEF);

    // Same-cycle write-to-read forwarding
    RegWE = 1'b1; wR = 5'd3; RegWd = 32'h1234_5678; rR2 = 5'd3;
    #1;
    chk("bypass_on", rD2_b, 32'h1234_5678);
    chk("bypass_off_old", rD2_n, 0);
    tick();
    RegWE = 1'b0;
    #1;
    chk("bypass_off_new", rD2_n, 32'h1234_5678);
    chk("bypass_on_after", rD2_b, 32'h1234_5678);

    // Register zero stays zero and never pending
    RegWE = 1'b1; wR = 5'd0; RegWd = 32'hFFFF_FFFF; pend_set = 1'b1; pend_rd = 5'd0;
    tick();
    idle(); rR1 = 5'd0; use1 = 1'b1;
    #1;
    chk("x0_rD1", rD1_b, 0);
    chk("x0_busy0", bv_b[0], 0);
    chk("x0_busy", bv_b, 0);
    chk("x0_hazard", hz_b, 0);

    // Load-use
    pend_set = 1'b1; pend_rd = 5'd9; rR1 = 5'd9; use1 = 1'b1;
    #1;
    chk("lu_same_cycle", hz_b, 0);
    tick();
    pend_set = 1'b0;
    #1;
    chk("lu_hazard_byp", hz_b, 1);
    chk("lu_hazard_nob", hz_n, 1);
    chk("lu_busy", bv_b, 32'h0000_0200);
    use1 = 1'b0;
    #1;
    chk("lu_unused", hz_b, 0);
    rR2 = 5'd9; use2 = 1'b1;
    #1;
    chk("lu_port2", hz_b, 1);
    use2 = 1'b0; use1 = 1'b1;
    RegWE = 1'b1; wR = 5'd9; RegWd = 32'hA5A5_A5A5;
    #1;
    chk("lu_wb_hazard_byp", hz_b, 0);
    chk("lu_wb_rD1_byp", rD1_b, 32'hA5A5_A5A5);
    chk("lu_wb_hazard_nob", hz_n, 1);
    chk("lu_wb_rD1_nob", rD1_n, 0);
    tick();
    RegWE = 1'b0;
    #1;
    chk("lu_busy_clr", bv_b, 0);
    chk("lu_hazard_clr_nob", hz_n, 0);
    chk("lu_rD1_nob", rD1_n, 32'hA5A5_A5A5);

    // Set/clear collision: set wins
    pend_set = 1'b1; pend_rd = 5'd4; RegWE = 1'b1; wR = 5'd4; RegWd = 32'h44;
    tick();
    idle();
    #1;
    chk("collide_busy", bv_b, 32'h0000_0010);
    chk("collide_busy_nob", bv_n, 32'h0000_0010);

    // Flush clears all marks, ignores pend_set, still writes
    flush = 1'b1; pend_set = 1'b1; pend_rd = 5'd6;
    RegWE = 1'b1; wR = 5'd2; RegWd = 32'h55;
    tick();
    idle(); rR1 = 5'd2; use1 = 1'b0;
    #1;
    chk("flush_busy", bv_b, 0);
    chk("flush_write", rD1_b, 32'h55);
    chk("flush_write_nob", rD1_n, 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
